// File: rtl/menu_sprite_addr_if.sv
// Pixel-side bus of the menu sprite address generator: raster position and menu controls in,
// frame-RAM address, RAM select, pixel-valid and exit pulse out.
interface menu_sprite_addr_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_sync;
  logic        menu_active;
  logic        start_key;
  logic [18:0] read_address;
  logic        frame_sel;
  logic        sprite_on;
  logic        menu_done;

  modport master (
    output DrawX, DrawY, frame_sync, menu_active, start_key,
    input  read_address, frame_sel, sprite_on, menu_done
  );

  modport slave (
    input  DrawX, DrawY, frame_sync, menu_active, start_key,
    output read_address, frame_sel, sprite_on, menu_done
  );
endinterface

// File: rtl/menu_sprite_addr.sv
// Menu sprite RAM addressing with blink/flash FSM. Latency: read_address 1 cycle, sprite_on 2
// cycles (matches registered RAM read); no backpressure, outputs follow the raster every cycle.
module menu_sprite_addr #(
  parameter int SPR_W        = 128,
  parameter int SPR_H        = 64,
  parameter int ORIGIN_X     = 256,
  parameter int ORIGIN_Y     = 208,
  parameter int BLINK_FRAMES = 30,
  parameter int FLASH_FRAMES = 8
) (
  input logic              Clk,
  input logic              Reset_n,
  menu_sprite_addr_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW, FLASH, DONE} state_t;

  // Window edges held one bit wider than DrawX/DrawY so an end column of 1024 does not wrap.
  localparam logic [10:0] X_LO    = 11'(ORIGIN_X);
  localparam logic [10:0] X_END   = 11'(ORIGIN_X + SPR_W);
  localparam logic [10:0] Y_LO    = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_END   = 11'(ORIGIN_Y + SPR_H);
  localparam logic [18:0] W19     = 19'(SPR_W);
  localparam logic [5:0]  BLINK_L = 6'(BLINK_FRAMES - 1);
  localparam logic [5:0]  FLASH_L = 6'(FLASH_FRAMES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        frame_sel_q, frame_sel_d;
  logic [18:0] read_address_q, read_address_d;
  logic        vis1_q, vis1_d;
  logic        vis2_q, vis2_d;

  logic        in_window;
  logic [9:0]  dx, dy;

  always_comb begin
    in_window = ({1'b0, bus.DrawX} >= X_LO) && ({1'b0, bus.DrawX} < X_END) &&
                ({1'b0, bus.DrawY} >= Y_LO) && ({1'b0, bus.DrawY} < Y_END);
    dx = bus.DrawX - X_LO[9:0];
    dy = bus.DrawY - Y_LO[9:0];
    // Offsets are only meaningful inside the window; outside, force zero so no wrap leaks out.
    read_address_d = in_window ? ({9'd0, dy} * W19 + {9'd0, dx}) : 19'd0;
    vis1_d = in_window && ((state_q == SHOW) || (state_q == FLASH));
    vis2_d = vis1_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_sel_d = frame_sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.menu_active) begin
          state_d     = SHOW;
          cnt_d       = 6'd0;
          frame_sel_d = 1'b0;
        end
      end
      SHOW: begin
        if (!bus.menu_active) begin
          state_d     = IDLE;
          cnt_d       = 6'd0;
          frame_sel_d = 1'b0;
        end else if (bus.start_key) begin
          state_d = FLASH;
          cnt_d   = 6'd0;
        end else if (bus.frame_sync) begin
          if (cnt_q == BLINK_L) begin
            frame_sel_d = ~frame_sel_q;
            cnt_d       = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      FLASH: begin
        if (!bus.menu_active) begin
          state_d     = IDLE;
          cnt_d       = 6'd0;
          frame_sel_d = 1'b0;
        end else if (bus.frame_sync) begin
          frame_sel_d = ~frame_sel_q;
          if (cnt_q == FLASH_L) begin
            state_d = DONE;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        cnt_d       = 6'd0;
        frame_sel_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 6'd0;
        frame_sel_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= 6'd0;
      frame_sel_q    <= 1'b0;
      read_address_q <= 19'd0;
      vis1_q         <= 1'b0;
      vis2_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      frame_sel_q    <= frame_sel_d;
      read_address_q <= read_address_d;
      vis1_q         <= vis1_d;
      vis2_q         <= vis2_d;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.frame_sel    = frame_sel_q;
  assign bus.sprite_on    = vis2_q;
  assign bus.menu_done    = (state_q == DONE);

endmodule

// File: tb/tb_menu_sprite_addr.sv
// Directed bench for menu_sprite_addr: addressing, window edges, blink, flash, abort and reset.
module tb_menu_sprite_addr;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_err;

  menu_sprite_addr_if bus ();

  menu_sprite_addr dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sync_pulse();
    bus.frame_sync = 1'b1;
    step();
    bus.frame_sync = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_err           = 0;
    Reset_n         = 1'b0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    bus.frame_sync  = 1'b0;
    bus.menu_active = 1'b0;
    bus.start_key   = 1'b0;

    // Reset state
    #12;
    chk("rst_addr", 32'(bus.read_address), 0);
    chk("rst_sel", 32'(bus.frame_sel), 0);
    chk("rst_spr", 32'(bus.sprite_on), 0);
    chk("rst_done", 32'(bus.menu_done), 0);
    Reset_n = 1'b1;
    step();

    // Address is computed in IDLE too, but sprite_on stays gated by state
    bus.DrawX = 10'd257;
    bus.DrawY = 10'd208;
    step();
    chk("idle_addr", 32'(bus.read_address), 1);
    step();
    chk("idle_spr", 32'(bus.sprite_on), 0);

    // Enter SHOW, origin pixel
    bus.menu_active = 1'b1;
    step();
    chk("show_sel0", 32'(bus.frame_sel), 0);
    bus.DrawX = 10'd256;
    bus.DrawY = 10'd208;
    step();
    chk("origin_addr", 32'(bus.read_address), 0);
    step();
    chk("origin_spr", 32'(bus.sprite_on), 1);

    // Last pixel of the sprite
    bus.DrawX = 10'd383;
    bus.DrawY = 10'd271;
    step();
    chk("last_addr", 32'(bus.read_address), 8191);
    step();
    chk("last_spr", 32'(bus.sprite_on), 1);

    // One column past the right edge
    bus.DrawX = 10'd384;
    bus.DrawY = 10'd271;
    step();
    chk("right_addr", 32'(bus.read_address), 0);
    step();
    chk("right_spr", 32'(bus.sprite_on), 0);

    // One row above the top edge
    bus.DrawX = 10'd300;
    bus.DrawY = 10'd207;
    step();
    chk("above_addr", 32'(bus.read_address), 0);
    step();
    chk("above_spr", 32'(bus.sprite_on), 0);

    // Left of window (no wrap), then an interior pixel: 12*128+44
    bus.DrawX = 10'd100;
    bus.DrawY = 10'd210;
    step();
    chk("left_addr", 32'(bus.read_address), 0);
    bus.DrawX = 10'd300;
    bus.DrawY = 10'd220;
    step();
    chk("mid_addr", 32'(bus.read_address), 1580);

    // Blink: toggle after 30 frames, back after 30 more
    bus.DrawX = 10'd256;
    bus.DrawY = 10'd208;
    for (int i = 0; i < 29; i++) begin
      sync_pulse();
      step();
    end
    chk("blink_29", 32'(bus.frame_sel), 0);
    sync_pulse();
    chk("blink_30", 32'(bus.frame_sel), 1);
    step();
    for (int i = 0; i < 29; i++) begin
      sync_pulse();
      step();
    end
    chk("blink_59", 32'(bus.frame_sel), 1);
    sync_pulse();
    chk("blink_60", 32'(bus.frame_sel), 0);
    step();

    // Flash: start_key, then 8 frames; a second start_key mid-flash is ignored
    bus.start_key = 1'b1;
    step();
    bus.start_key = 1'b0;
    chk("flash_entry_sel", 32'(bus.frame_sel), 0);
    for (int i = 1; i <= 7; i++) begin
      sync_pulse();
      chk("flash_sel", 32'(bus.frame_sel), 32'(i % 2));
      chk("flash_nodone", 32'(bus.menu_done), 0);
      if (i == 3) bus.start_key = 1'b1;
      step();
      bus.start_key = 1'b0;
    end
    chk("flash_spr", 32'(bus.sprite_on), 1);
    sync_pulse();
    chk("flash_done", 32'(bus.menu_done), 1);
    chk("flash_sel8", 32'(bus.frame_sel), 0);
    step();
    chk("done_one_cycle", 32'(bus.menu_done), 0);
    chk("idle_sel", 32'(bus.frame_sel), 0);

    // Back in SHOW; start_key coincident with frame_sync enters FLASH with counter 0
    step();
    bus.start_key  = 1'b1;
    bus.frame_sync = 1'b1;
    step();
    bus.start_key  = 1'b0;
    bus.frame_sync = 1'b0;
    chk("coinc_sel", 32'(bus.frame_sel), 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      sync_pulse();
      chk("coinc_sel_t", 32'(bus.frame_sel), 32'(i % 2));
      chk("coinc_nodone", 32'(bus.menu_done), 0);
    end

    // Abort mid-FLASH: no done pulse, sprite disappears
    bus.menu_active = 1'b0;
    step();
    chk("abort_done0", 32'(bus.menu_done), 0);
    sync_pulse();
    chk("abort_done1", 32'(bus.menu_done), 0);
    step();
    chk("abort_spr", 32'(bus.sprite_on), 0);

    // Async reset mid-FLASH
    bus.menu_active = 1'b1;
    bus.DrawX       = 10'd257;
    step();
    bus.start_key = 1'b1;
    step();
    bus.start_key = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sync_pulse();
      step();
    end
    chk("pre_rst_addr", 32'(bus.read_address), 1);
    chk("pre_rst_sel", 32'(bus.frame_sel), 1);
    chk("pre_rst_spr", 32'(bus.sprite_on), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.read_address), 0);
    chk("arst_sel", 32'(bus.frame_sel), 0);
    chk("arst_spr", 32'(bus.sprite_on), 0);
    chk("arst_done", 32'(bus.menu_done), 0);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sync_pulse();
      chk("post_rst_done", 32'(bus.menu_done), 0);
      step();
      chk("post_rst_done2", 32'(bus.menu_done), 0);
    end
    chk("post_rst_sel", 32'(bus.frame_sel), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
